fwd_hazard_unit: RTL

Parametrised forwarding and load-use hazard unit for the pipelined RV32 core. It tracks destination registers in flight through a configurable number of post-EX stages in an internal shift pipeline, and gives each EX-stage source operand a forward select naming the youngest producing stage. It detects load-use hazards for ID-stage sources and requests a stall. It sits beside the ID/EX register; the forward selects drive the EX operand muxes and the stall drives PC/IF-ID hold and the ID/EX bubble.

---
 rtl/fwd_pkg.sv | 15 +
 rtl/fwd_src_match.sv | 33 +++
 rtl/fwd_hazard_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
package fwd_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Forward select value meaning "take the operand from the register file".
  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } stage_t;

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand priority search over the in-flight stages; the youngest matching producer wins.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SELW       = 2
) (
  input  stage_t [DEPTH-1:0] stages,
  input  logic   [4:0]       rs,
  output logic   [SELW-1:0]  sel
);

  logic found;

  always_comb begin
    sel   = SELW'(FWD_RF);
    found = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (!found && stages[k-1].wr && (stages[k-1].rd == rs)) begin
        found = 1'b1;
        // Load data not yet available here; the match still shadows older stages.
        if (!(stages[k-1].ld && (k < LOAD_STAGE))) begin
          sel = SELW'(k);
        end
      end
    end
    if (rs == REG_X0) begin
      sel = SELW'(FWD_RF);
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation for the RV32 pipeline, tracking
// destination registers through DEPTH post-EX stages.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold_i,
  input  logic                    flush_i,
  input  logic                    ex_valid_i,
  input  logic                    ex_regwrite_i,
  input  logic                    ex_is_load_i,
  input  logic [4:0]              ex_rd_i,
  input  logic [5*NUM_SRC-1:0]    ex_rs_i,
  input  logic [5*NUM_SRC-1:0]    id_rs_i,
  input  logic [NUM_SRC-1:0]      id_rs_used_i,
  output logic [SELW*NUM_SRC-1:0] fwd_sel_o,
  output logic                    stall_o,
  output logic [31:0]             stall_cnt_o
);

  stage_t [DEPTH-1:0] stage_q, stage_d;
  logic   [31:0]      stall_cnt_q;
  logic               ex_load_live;
  logic [NUM_SRC-1:0] src_hazard;

  assign ex_load_live = ex_valid_i && ex_regwrite_i && ex_is_load_i && (ex_rd_i != REG_X0);

  always_comb begin
    src_hazard = '0;
    for (int p = 0; p < NUM_SRC; p++) begin
      if (id_rs_used_i[p] && (id_rs_i[5*p +: 5] != REG_X0)) begin
        if (ex_load_live && (ex_rd_i == id_rs_i[5*p +: 5])) begin
          src_hazard[p] = 1'b1;
        end
        // Loads still short of LOAD_STAGE by more than one stage cannot be
        // reached by the time the ID instruction gets to EX.
        for (int k = 1; k <= LOAD_STAGE - 2; k++) begin
          if (stage_q[k-1].wr && stage_q[k-1].ld && (stage_q[k-1].rd == id_rs_i[5*p +: 5])) begin
            src_hazard[p] = 1'b1;
          end
        end
      end
    end
  end

  assign stall_o = (|src_hazard) && !flush_i;

  // The stall holds ID and bubbles ID/EX outside this block; the EX instruction
  // itself (typically the load) must still advance into stage 1.
  always_comb begin
    stage_d = stage_q;
    if (!hold_i) begin
      stage_d[0].wr = ex_valid_i && ex_regwrite_i && (ex_rd_i != REG_X0) && !flush_i;
      stage_d[0].ld = stage_d[0].wr && ex_is_load_i;
      stage_d[0].rd = ex_rd_i;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_o && !hold_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_src
    fwd_src_match #(
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .SELW       (SELW)
    ) u_match (
      .stages (stage_q),
      .rs     (ex_rs_i[5*p +: 5]),
      .sel    (fwd_sel_o[SELW*p +: SELW])
    );
  end

endmodule
